trigger_capture: RTL and testbench
==================================

# trigger_capture

Parametrised multi-channel trigger and capture engine for the oscilloscope datapath. It sits between the ADC sample stream and `draw_display`. It replaces the fixed single-channel 256-sample trigger buffer with a configurable circular capture memory that adds:
- pre-trigger depth;
- rising, falling or either-edge detection on a selectable channel;
- normal, auto and single acquisition modes;
- a read port that returns samples in time order, with logical index 0 being the oldest.

## Interface
- `DATA_W`, 12, sample width per channel
- `DEPTH`, 256, samples stored per channel; must be a power of two, ≥ 4
- `CHANNELS`, 2, number of captured channels, ≥ 1
- `AUTO_TIMEOUT`, 65536, accepted samples in ARMED before auto mode forces a trigger
- `clk` in 1: single clock; all logic on its rising edge
- `rst` in 1: asynchronous, active-high reset
- `sample_valid` in 1: qualifies `sample_data` this cycle
- `sample_data` in CHANNELS*DATA_W: channel k at bits [k*DATA_W +: DATA_W]
- `trig_channel` in $clog2(CHANNELS) (min 1): channel compared against level
- `trig_level` in DATA_W: unsigned threshold
- `trig_edge` in 2: 00 rising, 01 falling, 10/11 either
- `mode` in 2: 00 normal, 01 auto, 10/11 single
- `pretrig` in $clog2(DEPTH): samples kept before the trigger sample
- `arm` in 1: pulse; starts acquisition from IDLE
- `abort` in 1: pulse; returns to IDLE from any state
- `release_buf` in 1: pulse; display has finished reading the buffer
- `rd_channel` in $clog2(CHANNELS) (min 1): read channel
- `rd_addr` in $clog2(DEPTH): logical read index, 0 = oldest
- `rd_data` out DATA_W: registered read data
- `busy` out 1: high in PRE_FILL, ARMED, POST
- `done` out 1: high in DONE
- `triggered` out 1: 1 = real edge trigger, 0 = auto-forced; valid while `done`=1
- `state` out 3: IDLE=0, PRE_FILL=1, ARMED=2, POST=3, DONE=4

## Operation
- **Sample acceptance**
  - A sample is accepted on a cycle with `sample_valid`=1 in PRE_FILL, ARMED or POST.
  - Every accepted sample writes all channels at `wr_ptr`, then `wr_ptr` increments modulo DEPTH.
- **Edge history**
  - `prev` holds the last accepted `trig_channel` sample. `prev_ok` is cleared on entry to PRE_FILL and set on the first accepted sample.
  - Rising: `prev` < `trig_level` ≤ `cur`. Falling: `prev` ≥ `trig_level` > `cur`. Either: rising OR falling.
  - An edge counts only while `prev_ok`=1.
- **Arming**
  - IDLE: `arm` latches `pretrig`, `mode`, `trig_edge`, `trig_channel` and `trig_level`, then enters PRE_FILL. These latched copies are used until the next arm.
- **PRE_FILL**
  - Counts accepted samples. After `pretrig` of them, moves to ARMED.
  - With `pretrig`=0, moves to ARMED on the cycle after arm.
- **ARMED**
  - An accepted sample that forms an edge is the trigger sample:
    - `start_ptr` ← (`wr_ptr` − `pretrig`) mod DEPTH;
    - `triggered` ← 1;
    - go to POST, or to DONE if `pretrig` = DEPTH−1.
  - Auto mode: a timeout counter increments on each accepted non-trigger sample. When it reaches AUTO_TIMEOUT, that sample is treated as the trigger sample with `triggered` ← 0.
- **POST**
  - Accepts DEPTH−1−`pretrig` further samples, then goes to DONE.
- **DONE**
  - No writes take place.
  - On `release_buf`: normal and auto modes re-enter PRE_FILL, clearing `prev_ok` and the counters and reusing the latched configuration. Single mode goes to IDLE.
- **Read port**
  - `rd_data` ← mem[`rd_channel`][(`start_ptr` + `rd_addr`) mod DEPTH], registered.
  - Reads are allowed in any state; contents are guaranteed coherent only while `done`=1.
- **Precedence and ignored inputs**
  - `abort` beats every other input and goes to IDLE; buffer contents are kept.
  - `arm` outside IDLE is ignored.
  - `release_buf` outside DONE is ignored.

## Timing
- **Reset values:**
  - `state`=IDLE;
  - `busy`, `done`, `triggered`=0;
  - `rd_data`=0;
  - `wr_ptr`, `start_ptr` and all counters = 0.
  - Memory contents are undefined.
- **Read latency:** `rd_data` reflects `rd_addr`/`rd_channel` one clock after they are presented. A new address may be presented every cycle.
- **Trigger latency:** the trigger sample is accepted in cycle N; `state` changes in N+1.
- **DONE entry:** the last POST sample is accepted in cycle N; `done`=1 from N+1.
- **Outputs:** `state`, `busy` and `done` are registered. They change only on clock edges or on `rst`.
- **Reset mid-capture:** returns to IDLE immediately; no `done` pulse is produced.
- **Stalls:** `sample_valid` gaps stall all counters; edge history spans the gaps.

## Test plan
Bench overrides: DEPTH=16, CHANNELS=2, AUTO_TIMEOUT=32.

1. **Rising-edge capture**
   - Stimulus: `mode`=normal, rising edge, `trig_level`=100, `pretrig`=4, ch0 ramp 90,92,94,…, ch1 = ch0+1000. Arm, then read all 16 samples.
   - Required: trigger on the first sample ≥100 (value 100). ch0 `rd_addr`=4 returns 100; `rd_addr`=0 returns 92; `rd_addr`=15 returns 122. ch1 `rd_addr`=4 returns 1100. `triggered`=1.
2. **Falling edge with stalls**
   - Stimulus: ch1 selected, falling edge, `trig_level`=50, `sample_valid` toggling 1-0-1.
   - Required: trigger on the first ch1 sample < 50; sample count is unaffected by the gaps.
3. **Auto timeout**
   - Stimulus: `mode`=auto, constant input 10, `trig_level`=100, `pretrig`=0.
   - Required: forced trigger on the 32nd accepted sample in ARMED. DONE after 15 further samples with `triggered`=0. `release_buf` then returns to PRE_FILL.
4. **Single mode**
   - Stimulus: after a completed capture, assert `release_buf`.
   - Required: `state`=IDLE. Further samples do not change `rd_data` at any address.
5. **Abort and arm collision**
   - Stimulus: `abort` together with `arm` in IDLE, then `abort` in POST.
   - Required: stays IDLE in the first case. Goes to IDLE without `done` in the second.
6. **Boundary `pretrig`**
   - Stimulus: (a) `pretrig`=15; (b) `pretrig`=0.
   - Required: (a) DONE the cycle after the trigger sample, and `rd_addr`=15 returns the trigger sample. (b) `rd_addr`=0 returns the trigger sample. `wr_ptr` wrap is verified with three consecutive normal-mode captures.

Source files
------------

// File: rtl/trigger_capture.sv
// Multi-channel trigger and capture engine: circular sample memory with pre-trigger
// depth, edge trigger on a selectable channel, normal/auto/single modes, ordered read-back.
module trigger_capture #(
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned DEPTH        = 256,
    parameter int unsigned CHANNELS     = 2,
    parameter int unsigned AUTO_TIMEOUT = 65536
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic                                               sample_valid,
    input  logic [CHANNELS*DATA_W-1:0]                         sample_data,
    input  logic [$clog2((CHANNELS > 1) ? CHANNELS : 2)-1:0]   trig_channel,
    input  logic [DATA_W-1:0]                                  trig_level,
    input  logic [1:0]                                         trig_edge,
    input  logic [1:0]                                         mode,
    input  logic [$clog2(DEPTH)-1:0]                           pretrig,
    input  logic                                               arm,
    input  logic                                               abort,
    input  logic                                               release_buf,
    input  logic [$clog2((CHANNELS > 1) ? CHANNELS : 2)-1:0]   rd_channel,
    input  logic [$clog2(DEPTH)-1:0]                           rd_addr,
    output logic [DATA_W-1:0]                                  rd_data,
    output logic                                               busy,
    output logic                                               done,
    output logic                                               triggered,
    output logic [2:0]                                         state
);

    localparam int unsigned CH_W = $clog2((CHANNELS > 1) ? CHANNELS : 2);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned TW   = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);
    localparam logic [1:0]    MODE_AUTO = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRE_FILL = 3'd1,
        S_ARMED    = 3'd2,
        S_POST     = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     start_ptr_q, start_ptr_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              prev_ok_q, prev_ok_d;
    logic [AW-1:0]     pretrig_q, pretrig_d;
    logic [1:0]        mode_q, mode_d;
    logic [1:0]        edge_sel_q, edge_sel_d;
    logic [CH_W-1:0]   chan_q, chan_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic              triggered_q, triggered_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic [DATA_W-1:0] chan_data [CHANNELS];
    logic [DATA_W-1:0] lane_rd   [CHANNELS];
    logic [DATA_W-1:0] cur_c;
    logic [AW-1:0]     rd_idx_c;
    logic              accept_c;
    logic              rise_c, fall_c, hit_c;

    assign accept_c = sample_valid && !abort &&
                      (state_q inside {S_PRE_FILL, S_ARMED, S_POST});
    assign rd_idx_c = start_ptr_q + rd_addr;

    // One memory lane per channel; every lane writes the same slot on acceptance
    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];

        assign chan_data[k] = sample_data[k*DATA_W +: DATA_W];
        assign lane_rd[k]   = mem[rd_idx_c];

        always_ff @(posedge clk) begin
            if (accept_c) begin
                mem[wr_ptr_q] <= chan_data[k];
            end
        end
    end

    assign cur_c  = chan_data[chan_q];
    assign rise_c = (prev_q < level_q) && (level_q <= cur_c);
    assign fall_c = (prev_q >= level_q) && (level_q > cur_c);

    always_comb begin
        case (edge_sel_q)
            2'b00:   hit_c = prev_ok_q && rise_c;
            2'b01:   hit_c = prev_ok_q && fall_c;
            default: hit_c = prev_ok_q && (rise_c || fall_c);
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        prev_d      = prev_q;
        prev_ok_d   = prev_ok_q;
        pretrig_d   = pretrig_q;
        mode_d      = mode_q;
        edge_sel_d  = edge_sel_q;
        chan_d      = chan_q;
        level_d     = level_q;
        triggered_d = triggered_q;
        rd_data_d   = lane_rd[rd_channel];

        if (accept_c) begin
            wr_ptr_d  = wr_ptr_q + AW'(1);
            prev_d    = cur_c;
            prev_ok_d = 1'b1;
        end

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arm) begin
                        pretrig_d   = pretrig;
                        mode_d      = mode;
                        edge_sel_d  = trig_edge;
                        chan_d      = trig_channel;
                        level_d     = trig_level;
                        cnt_d       = '0;
                        tmo_d       = '0;
                        prev_ok_d   = 1'b0;
                        triggered_d = 1'b0;
                        state_d     = S_PRE_FILL;
                    end
                end
                S_PRE_FILL: begin
                    if (pretrig_q == '0) begin
                        state_d = S_ARMED;
                    end else if (accept_c) begin
                        if (cnt_q + AW'(1) == pretrig_q) begin
                            cnt_d   = '0;
                            state_d = S_ARMED;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                end
                S_ARMED: begin
                    if (accept_c) begin
                        if (hit_c || (mode_q == MODE_AUTO &&
                                      tmo_q + TW'(1) == TW'(AUTO_TIMEOUT))) begin
                            start_ptr_d = wr_ptr_q - pretrig_q;
                            triggered_d = hit_c;
                            cnt_d       = '0;
                            state_d     = (pretrig_q == LAST_IDX) ? S_DONE : S_POST;
                        end else if (mode_q == MODE_AUTO) begin
                            tmo_d = tmo_q + TW'(1);
                        end
                    end
                end
                S_POST: begin
                    if (accept_c) begin
                        if (cnt_q + AW'(1) == LAST_IDX - pretrig_q) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d = cnt_q + AW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (release_buf) begin
                        cnt_d       = '0;
                        tmo_d       = '0;
                        prev_ok_d   = 1'b0;
                        triggered_d = 1'b0;
                        state_d     = mode_q[1] ? S_IDLE : S_PRE_FILL;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = state_d inside {S_PRE_FILL, S_ARMED, S_POST};
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            cnt_q       <= '0;
            tmo_q       <= '0;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            pretrig_q   <= '0;
            mode_q      <= '0;
            edge_sel_q  <= '0;
            chan_q      <= '0;
            level_q     <= '0;
            triggered_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            prev_q      <= prev_d;
            prev_ok_q   <= prev_ok_d;
            pretrig_q   <= pretrig_d;
            mode_q      <= mode_d;
            edge_sel_q  <= edge_sel_d;
            chan_q      <= chan_d;
            level_q     <= level_d;
            triggered_q <= triggered_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign state     = state_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign triggered = triggered_q;
    assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Self-checking bench for trigger_capture: directed corner cases plus randomized
// acquisitions checked against a sample-log reference model.
module tb_trigger_capture;

    localparam int unsigned DATA_W       = 12;
    localparam int unsigned DEPTH        = 16;
    localparam int unsigned CHANNELS     = 2;
    localparam int unsigned AUTO_TIMEOUT = 32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       sample_valid;
    logic [CHANNELS*DATA_W-1:0] sample_data;
    logic [0:0]                 trig_channel;
    logic [DATA_W-1:0]          trig_level;
    logic [1:0]                 trig_edge;
    logic [1:0]                 mode;
    logic [3:0]                 pretrig;
    logic                       arm;
    logic                       abort;
    logic                       release_buf;
    logic [0:0]                 rd_channel;
    logic [3:0]                 rd_addr;
    logic [DATA_W-1:0]          rd_data;
    logic                       busy;
    logic                       done;
    logic                       triggered;
    logic [2:0]                 state;

    trigger_capture #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
        .trig_channel(trig_channel), .trig_level(trig_level), .trig_edge(trig_edge),
        .mode(mode), .pretrig(pretrig), .arm(arm), .abort(abort),
        .release_buf(release_buf), .rd_channel(rd_channel), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .triggered(triggered), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int addr;
        int exp;
    } rd_vec_t;

    int checks = 0;
    int errors = 0;

    logic [11:0] log0[$];
    logic [11:0] log1[$];
    int          gen_kind;
    int          gen_n;
    int          gen_base;
    logic [11:0] gen_lvl;

    int          cfg_pre;
    logic [1:0]  cfg_edge;
    logic [1:0]  cfg_mode;
    int          cfg_ch;
    logic [11:0] cfg_lvl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [11:0] near(input logic [11:0] lvl);
        int v;
        v = int'(lvl) + int'($urandom_range(0, 24)) - 12;
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
        return 12'(v);
    endfunction

    function automatic logic [31:0] getlog(input int ch, input int i);
        if (i < 0 || i >= log0.size()) return 'x;
        return ch != 0 ? 32'(log1[i]) : 32'(log0[i]);
    endfunction

    // Reference: scan the accepted-sample log of this acquisition for the trigger sample
    function automatic void find_trig(output int idx, output bit real_t);
        logic [11:0] p, c;
        bit rise, fall, hit;
        idx    = -1;
        real_t = 1'b0;
        for (int i = cfg_pre; i < log0.size(); i++) begin
            if (i >= 1) begin
                p    = (cfg_ch != 0) ? log1[i-1] : log0[i-1];
                c    = (cfg_ch != 0) ? log1[i]   : log0[i];
                rise = (p < cfg_lvl) && (cfg_lvl <= c);
                fall = (p >= cfg_lvl) && (cfg_lvl > c);
                hit  = (cfg_edge == 2'b00) ? rise : (cfg_edge == 2'b01) ? fall : (rise || fall);
                if (hit) begin
                    idx    = i;
                    real_t = 1'b1;
                    return;
                end
            end
            if (cfg_mode == 2'b01 && i == cfg_pre + int'(AUTO_TIMEOUT) - 1) begin
                idx = i;
                return;
            end
        end
    endfunction

    task automatic next_sample(output logic [11:0] c0, output logic [11:0] c1);
        case (gen_kind)
            0: begin c0 = 12'(gen_base + 2 * gen_n); c1 = 12'(gen_base + 2 * gen_n + 1000); end
            1: begin c0 = 12'($urandom); c1 = 12'(60 - 2 * gen_n); end
            2: begin c0 = 12'd10; c1 = 12'd10; end
            default: begin c0 = near(gen_lvl); c1 = near(gen_lvl); end
        endcase
        gen_n++;
    endtask

    task automatic do_arm(input int pre, input logic [1:0] ed, input logic [1:0] md,
                          input int ch, input logic [11:0] lvl);
        @(negedge clk);
        pretrig = 4'(pre); trig_edge = ed; mode = md; trig_channel = 1'(ch);
        trig_level = lvl; arm = 1'b1; sample_valid = 1'b0;
        cfg_pre = pre; cfg_edge = ed; cfg_mode = md; cfg_ch = ch; cfg_lvl = lvl;
        @(negedge clk);
        arm = 1'b0;
        pretrig = 4'($urandom); trig_edge = 2'($urandom); mode = 2'($urandom);
        trig_channel = 1'($urandom); trig_level = 12'($urandom);
        log0.delete(); log1.delete(); gen_n = 0;
    endtask

    task automatic do_release();
        @(negedge clk);
        release_buf = 1'b1; sample_valid = 1'b0;
        @(negedge clk);
        release_buf = 1'b0;
        log0.delete(); log1.delete(); gen_n = 0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1; sample_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
    endtask

    // vmode: 0 always valid, 1 toggling 1-0-1, 2 random gaps
    task automatic acquire(input int vmode, input int budget, output int n_acc, output bit ok);
        logic [11:0] c0, c1;
        bit v;
        n_acc = 0;
        ok    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : ($urandom_range(0, 3) != 0);
            sample_valid = v;
            if (v) begin
                next_sample(c0, c1);
                sample_data = {c1, c0};
                log0.push_back(c0);
                log1.push_back(c1);
                n_acc++;
            end
        end
        sample_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", budget);
        end
    endtask

    task automatic rd(input int ch, input int a, output logic [11:0] d);
        rd_channel = 1'(ch);
        rd_addr    = 4'(a);
        @(negedge clk);
        d = rd_data;
    endtask

    task automatic check_capture(input string tag, input int n_acc);
        int idx;
        bit real_t;
        logic [11:0] d;
        find_trig(idx, real_t);
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL %s_model: got no trigger in %0d samples, expected one", tag, n_acc);
            return;
        end
        chk({tag, "_count"}, n_acc, idx + int'(DEPTH) - cfg_pre);
        chk({tag, "_state"}, state, 4);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_triggered"}, triggered, real_t);
        for (int ch = 0; ch < 2; ch++) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                rd(ch, a, d);
                chk($sformatf("%s_rd_ch%0d_a%0d", tag, ch, a), d, getlog(ch, idx - cfg_pre + a));
            end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation time limit, expected completion");
        $fatal(1);
    end

    initial begin : main
        rd_vec_t     tbl[8];
        int          n;
        bit          ok;
        bit          saw_done;
        logic [11:0] d;
        int          pre, ch;
        logic [1:0]  ed, md;
        logic [11:0] lvl;

        tbl[0] = '{0, 4, 100};  tbl[1] = '{0, 0, 92};   tbl[2] = '{0, 15, 122};
        tbl[3] = '{1, 4, 1100}; tbl[4] = '{0, 5, 102};  tbl[5] = '{1, 0, 1092};
        tbl[6] = '{1, 15, 1122}; tbl[7] = '{0, 3, 98};

        rst = 1'b1; sample_valid = 1'b0; sample_data = '0; trig_channel = '0;
        trig_level = '0; trig_edge = '0; mode = '0; pretrig = '0; arm = 1'b0;
        abort = 1'b0; release_buf = 1'b0; rd_channel = '0; rd_addr = '0;
        gen_kind = 0; gen_n = 0; gen_base = 0; gen_lvl = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", state, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_rd_data", rd_data, 0);
        rst = 1'b0;

        // Rising-edge capture on a ramp
        gen_kind = 0; gen_base = 90;
        do_arm(4, 2'b00, 2'b00, 0, 12'd100);
        acquire(0, 200, n, ok);
        chk("rise_count_hand", n, 17);
        chk("rise_triggered", triggered, 1);
        for (int i = 0; i < 8; i++) begin
            rd(tbl[i].ch, tbl[i].addr, d);
            chk($sformatf("rise_tbl%0d", i), d, tbl[i].exp);
        end
        check_capture("rise", n);

        // Falling edge on ch1 with 1-0-1 valid gaps
        do_abort();
        gen_kind = 1;
        do_arm(3, 2'b01, 2'b00, 1, 12'd50);
        acquire(1, 200, n, ok);
        chk("fall_count_hand", n, 19);
        rd(1, 3, d); chk("fall_trig_sample", d, 48);
        rd(1, 0, d); chk("fall_oldest", d, 54);
        check_capture("fall", n);

        // Auto-mode forced trigger
        do_abort();
        gen_kind = 2;
        do_arm(0, 2'b00, 2'b01, 0, 12'd100);
        acquire(0, 200, n, ok);
        chk("auto_count_hand", n, 47);
        chk("auto_triggered", triggered, 0);
        check_capture("auto", n);
        do_release();
        chk("auto_release_state", state, 1);
        @(negedge clk);
        chk("auto_rearm_state", state, 2);

        // Single mode: release returns to IDLE and later samples are not written
        do_abort();
        gen_kind = 0; gen_base = 90;
        do_arm(5, 2'b00, 2'b10, 0, 12'd100);
        acquire(0, 200, n, ok);
        check_capture("single", n);
        @(negedge clk);
        release_buf = 1'b1;
        @(negedge clk);
        release_buf = 1'b0;
        chk("single_release_state", state, 0);
        for (int c = 0; c < 20; c++) begin
            sample_valid = 1'b1;
            sample_data  = {12'($urandom), 12'($urandom)};
            @(negedge clk);
        end
        sample_valid = 1'b0;
        for (int a = 0; a < 16; a += 5) begin
            rd(0, a, d); chk($sformatf("single_hold_ch0_a%0d", a), d, getlog(0, a));
            rd(1, a, d); chk($sformatf("single_hold_ch1_a%0d", a), d, getlog(1, a));
        end

        // abort together with arm in IDLE stays IDLE
        @(negedge clk);
        abort = 1'b1; arm = 1'b1;
        @(negedge clk);
        abort = 1'b0; arm = 1'b0;
        chk("abort_arm_state", state, 0);
        chk("abort_arm_busy", busy, 0);

        // abort in POST returns to IDLE without done
        gen_kind = 0; gen_base = 90;
        do_arm(2, 2'b00, 2'b00, 0, 12'd100);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (state === 3'd3) begin
                ok = 1'b1;
                break;
            end
            sample_valid = 1'b1;
            next_sample(d, lvl);
            sample_data = {lvl, d};
        end
        chk("abort_reached_post", ok, 1);
        abort = 1'b1; sample_valid = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_post_state", state, 0);
        chk("abort_post_done", done, 0);
        saw_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            sample_valid = 1'b1;
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        sample_valid = 1'b0;
        chk("abort_post_no_done", saw_done, 0);

        // pretrig = DEPTH-1: DONE right after the trigger sample
        gen_kind = 0; gen_base = 40;
        do_arm(15, 2'b00, 2'b00, 0, 12'd100);
        acquire(0, 200, n, ok);
        chk("pre15_count_hand", n, 31);
        rd(0, 15, d); chk("pre15_last_is_trig", d, 100);
        check_capture("pre15", n);

        // pretrig = 0: oldest slot is the trigger sample
        do_abort();
        gen_kind = 0; gen_base = 90;
        do_arm(0, 2'b00, 2'b00, 0, 12'd100);
        acquire(0, 200, n, ok);
        chk("pre0_count_hand", n, 21);
        rd(0, 0, d); chk("pre0_first_is_trig", d, 100);
        check_capture("pre0", n);

        // Three consecutive normal captures through release (wr_ptr wraps)
        do_abort();
        gen_kind = 3; gen_lvl = 12'd2000;
        do_arm(7, 2'b00, 2'b00, 1, 12'd2000);
        for (int k = 0; k < 3; k++) begin
            acquire(2, 2000, n, ok);
            if (ok) check_capture($sformatf("wrap%0d", k), n);
            do_release();
        end

        // Reset mid-capture: IDLE immediately, no done
        do_abort();
        gen_kind = 3;
        do_arm(3, 2'b10, 2'b00, 0, 12'd2000);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sample_valid = 1'b1;
            sample_data  = {near(gen_lvl), near(gen_lvl)};
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_state", state, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        rst = 1'b0; sample_valid = 1'b0;

        // Randomized acquisitions against the log model
        for (int it = 0; it < 10; it++) begin
            do_abort();
            pre = int'($urandom_range(0, 15));
            ed  = 2'($urandom_range(0, 3));
            md  = 2'($urandom_range(0, 3));
            ch  = int'($urandom_range(0, 1));
            lvl = 12'($urandom_range(20, 4000));
            gen_kind = 3; gen_lvl = lvl;
            do_arm(pre, ed, md, ch, lvl);
            acquire(2, 2000, n, ok);
            if (ok) check_capture($sformatf("rand%0d", it), n);
            if (ok && !md[1]) begin
                do_release();
                acquire(2, 2000, n, ok);
                if (ok) check_capture($sformatf("rand%0d_rearm", it), n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
